// File: rtl/gray_sync_rx.sv
// Destination-domain gray-code synchroniser: sync chain, gray->binary, update/delta/direction
// reporting and illegal-transition detection. Optional GRAY_SYNC_HOLD_ON_ERR_EN holds the output on errors.
module gray_sync_rx #(
  parameter int WIDTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int PRIME_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_valid,
  output logic             o_upd,
  output logic             o_dir,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_err,
  output logic             o_err_sticky
);

  localparam int PRIME_LEN = SYNC_STAGES + PRIME_CYCLES;
  localparam int CW        = $clog2(PRIME_LEN + 1);

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] prime_cnt;
  logic          prime_done;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] g_new, bin_new, diff, delta_new;
  logic             run, multi_bit, err_now, hold, upd_now;

  // Plain flop chain: nothing between stages so metastability has a full cycle to resolve.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync <= '0;
    end else begin
      sync[0] <= i_gray;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
    end
  end

  assign g_new = sync[SYNC_STAGES-1];

  always_comb begin
    bin_new = '0;
    for (int i = 0; i < WIDTH; i++) bin_new[i] = ^(g_new >> i);
  end

  // More than one bit set in the xor means a non-gray step.
  assign diff      = g_new ^ o_gray;
  assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;
  assign delta_new = bin_new - o_bin;

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= PRIME;
      prime_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == PRIME && !prime_done) prime_cnt <= prime_cnt + CW'(1);
    end
  end

  assign prime_done = (prime_cnt == CW'(PRIME_LEN - 1));

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (state == PRIME && prime_done) state_nxt = RUN;
  end

  // FSM: outputs
  always_comb begin
    run     = (state == RUN);
    o_valid = run;
  end

  assign err_now = run && multi_bit;

`ifdef GRAY_SYNC_HOLD_ON_ERR_EN
  assign hold = err_now;
`else
  assign hold = 1'b0;
`endif

  assign upd_now = run && (g_new != o_gray) && !hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bin        <= '0;
      o_gray       <= '0;
      o_upd        <= 1'b0;
      o_dir        <= 1'b0;
      o_delta      <= '0;
      o_err        <= 1'b0;
      o_err_sticky <= 1'b0;
    end else begin
      if (!hold) begin
        o_bin  <= bin_new;
        o_gray <= g_new;
      end
      o_upd <= upd_now;
      if (upd_now) begin
        o_delta <= delta_new;
        o_dir   <= !delta_new[WIDTH-1];
      end
      o_err <= err_now;
      // A new error outranks a clear in the same cycle.
      if (err_now)        o_err_sticky <= 1'b1;
      else if (i_err_clr) o_err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_sync_rx.sv
// Directed vector bench for gray_sync_rx (WIDTH=4, SYNC_STAGES=2, PRIME_CYCLES=2), default build.
module tb_gray_sync_rx;

  logic       i_clk = 1'b0;
  logic       i_rst, i_err_clr;
  logic [3:0] i_gray;
  logic [3:0] o_bin, o_gray, o_delta;
  logic       o_valid, o_upd, o_dir, o_err, o_err_sticky;

  int errors = 0;
  int checks = 0;
  int cur    = 0;

  typedef struct {
    logic       rst, clr;
    logic [3:0] g;
    logic [3:0] bin;
    logic       upd, dir;
    logic [3:0] dlt;
    logic       err, stk, vld;
  } vec_t;

  vec_t tv[$];

  gray_sync_rx #(.WIDTH(4), .SYNC_STAGES(2), .PRIME_CYCLES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_gray(i_gray), .i_err_clr(i_err_clr),
    .o_bin(o_bin), .o_gray(o_gray), .o_valid(o_valid), .o_upd(o_upd),
    .o_dir(o_dir), .o_delta(o_delta), .o_err(o_err), .o_err_sticky(o_err_sticky)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  task automatic row(input logic rst, clr, input logic [3:0] g, bin, input logic upd, dir,
                     input logic [3:0] dlt, input logic err, stk, vld);
    vec_t v;
    v.rst = rst; v.clr = clr; v.g = g; v.bin = bin; v.upd = upd; v.dir = dir;
    v.dlt = dlt; v.err = err; v.stk = stk; v.vld = vld;
    tv.push_back(v);
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    i_rst = 1'b1; i_err_clr = 1'b0; i_gray = 4'h0;

    //   rst clr g     bin   upd dir dlt   err stk vld
    row(1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    row(1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 1);  // valid after 4th edge
    row(0, 0, 4'h2, 4'h0, 0, 0, 4'h0, 0, 0, 1);  // step to 3
    row(0, 0, 4'h2, 4'h0, 0, 0, 4'h0, 0, 0, 1);
    row(0, 0, 4'h2, 4'h3, 1, 1, 4'h3, 0, 0, 1);
    row(0, 0, 4'h6, 4'h3, 0, 1, 4'h3, 0, 0, 1);  // 3 -> 4
    row(0, 0, 4'h6, 4'h3, 0, 1, 4'h3, 0, 0, 1);
    row(0, 0, 4'h6, 4'h4, 1, 1, 4'h1, 0, 0, 1);
    row(0, 0, 4'h2, 4'h4, 0, 1, 4'h1, 0, 0, 1);  // count down 4..0 then wrap to 15
    row(0, 0, 4'h3, 4'h4, 0, 1, 4'h1, 0, 0, 1);
    row(0, 0, 4'h1, 4'h3, 1, 0, 4'hF, 0, 0, 1);
    row(0, 0, 4'h0, 4'h2, 1, 0, 4'hF, 0, 0, 1);
    row(0, 0, 4'h8, 4'h1, 1, 0, 4'hF, 0, 0, 1);
    row(0, 0, 4'h8, 4'h0, 1, 0, 4'hF, 0, 0, 1);
    row(0, 0, 4'h8, 4'hF, 1, 0, 4'hF, 0, 0, 1);
    row(0, 0, 4'h0, 4'hF, 0, 0, 4'hF, 0, 0, 1);  // wrap back up 15 -> 0
    row(0, 0, 4'h0, 4'hF, 0, 0, 4'hF, 0, 0, 1);
    row(0, 0, 4'h0, 4'h0, 1, 1, 4'h1, 0, 0, 1);
    row(0, 0, 4'h3, 4'h0, 0, 1, 4'h1, 0, 0, 1);  // illegal 0000 -> 0011
    row(0, 0, 4'h3, 4'h0, 0, 1, 4'h1, 0, 0, 1);
    row(0, 0, 4'h0, 4'h2, 1, 1, 4'h2, 1, 1, 1);  // illegal 0011 -> 0000 follows
    row(0, 0, 4'h0, 4'h2, 0, 1, 4'h2, 0, 1, 1);
    row(0, 1, 4'h0, 4'h0, 1, 0, 4'hE, 1, 1, 1);  // clear loses to error
    row(0, 1, 4'h0, 4'h0, 0, 0, 4'hE, 0, 0, 1);  // clear alone
    row(0, 0, 4'h0, 4'h0, 0, 0, 4'hE, 0, 0, 1);
    row(0, 0, 4'h8, 4'h0, 0, 0, 4'hE, 0, 0, 1);  // walk 0 -> 15 -> 8 -> 9
    row(0, 0, 4'hC, 4'h0, 0, 0, 4'hE, 0, 0, 1);
    row(0, 0, 4'hD, 4'hF, 1, 0, 4'hF, 0, 0, 1);
    row(0, 0, 4'hD, 4'h8, 1, 0, 4'h9, 0, 0, 1);
    row(0, 0, 4'hD, 4'h9, 1, 1, 4'h1, 0, 0, 1);
    row(0, 0, 4'hD, 4'h9, 0, 1, 4'h1, 0, 0, 1);

    foreach (tv[i]) begin
      cur = i;
      i_rst = tv[i].rst; i_err_clr = tv[i].clr; i_gray = tv[i].g;
      @(posedge i_clk); #1;
      chk("bin",    o_bin,        tv[i].bin);
      chk("gray",   o_gray,       to_gray(tv[i].bin));
      chk("upd",    o_upd,        tv[i].upd);
      chk("dir",    o_dir,        tv[i].dir);
      chk("delta",  o_delta,      tv[i].dlt);
      chk("err",    o_err,        tv[i].err);
      chk("sticky", o_err_sticky, tv[i].stk);
      chk("valid",  o_valid,      tv[i].vld);
    end

    // Mid-run reset with o_bin = 9, then re-prime with i_gray held at 1101.
    cur = 100;
    i_rst = 1'b1; i_err_clr = 1'b0; i_gray = 4'hD;
    @(posedge i_clk); #1;
    chk("rst_bin",   o_bin,   0);
    chk("rst_gray",  o_gray,  0);
    chk("rst_delta", o_delta, 0);
    chk("rst_dir",   o_dir,   0);
    chk("rst_valid", o_valid, 0);
    i_rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cur = 100 + c;
      @(posedge i_clk); #1;
      chk("reprime_valid", o_valid, (c >= 4) ? 1 : 0);
      chk("reprime_err",   o_err,   0);
      chk("reprime_upd",   o_upd,   0);
      chk("reprime_bin",   o_bin,   (c >= 3) ? 9 : 0);
    end
    chk("reprime_sticky", o_err_sticky, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
